// File: rtl/chess_board_ctrl_if.sv
// Button / display bundle for chess_board_ctrl.
//   master : button debouncers + frame timing side (drives pulses, reads status)
//   slave  : chess_board_ctrl (reads pulses, drives board image and status)
// Signals:
//   btn_up/down/left/right  one-cycle cursor move pulses
//   btn_sel, btn_cancel     one-cycle pick/place and drop pulses
//   new_game                one-cycle pulse, reload the initial position
//   frame_end               one-cycle pulse at end of visible frame
//   board_data              published 64 x 12-bit board image
//   turn, picked, game_over, winner, err, move_cnt   live status
interface chess_board_ctrl_if #(
   parameter int CNT_W = 10
);
   logic             btn_up;
   logic             btn_down;
   logic             btn_left;
   logic             btn_right;
   logic             btn_sel;
   logic             btn_cancel;
   logic             new_game;
   logic             frame_end;
   logic [767:0]     board_data;
   logic             turn;
   logic             picked;
   logic             game_over;
   logic             winner;
   logic             err;
   logic [CNT_W-1:0] move_cnt;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel,
             new_game, frame_end,
      input  board_data, turn, picked, game_over, winner, err, move_cnt
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel,
             new_game, frame_end,
      output board_data, turn, picked, game_over, winner, err, move_cnt
   );
endinterface

// File: rtl/chess_board_ctrl.sv
// Game-state controller for the board display datapath.
// Keeps the working board (piece per square), the cursor, the pick/place
// sequence and the game status; copies the rendered board into board_data
// only on frame_end so the display never sees a half-updated image.
// Ports:
//   pclk  pixel clock, sole clock
//   rstn  asynchronous active-low reset
//   bus   chess_board_ctrl_if.slave (button pulses in, board image/status out)
// Square word: [11:9] type, [8] camp (1 black), [7] occupied, [3] cursor,
// [2] picked source, other bits zero.
module chess_board_ctrl #(
   parameter int INIT_ROW = 6,
   parameter int INIT_COL = 4,
   parameter int CNT_W    = 10
) (
   input logic                pclk,
   input logic                rstn,
   chess_board_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_PICK,
      ST_PLACE,
      ST_MOVE,
      ST_OVER
   } state_t;

   // Piece field stored per square: {type[2:0], camp, occupied} = word bits 11..7.
   function automatic logic [4:0] init_piece(input int sq);
      logic [2:0] back;
      logic [4:0] res;
      case (sq % 8)
         0, 7:    back = 3'b101;
         1, 6:    back = 3'b100;
         2, 5:    back = 3'b011;
         3:       back = 3'b010;
         default: back = 3'b001;
      endcase
      case (sq / 8)
         0:       res = {back,   1'b1, 1'b1};
         1:       res = {3'b110, 1'b1, 1'b1};
         6:       res = {3'b110, 1'b0, 1'b1};
         7:       res = {back,   1'b0, 1'b1};
         default: res = 5'b00000;
      endcase
      return res;
   endfunction

   function automatic logic [11:0] init_word(input int sq);
      return {init_piece(sq), 3'b000, (sq == INIT_ROW * 8 + INIT_COL), 3'b000};
   endfunction

   state_t           state_reg, state_next;
   logic [2:0]       row_reg, row_next;
   logic [2:0]       col_reg, col_next;
   logic [5:0]       src_reg, src_next;
   logic [5:0]       dst_reg, dst_next;
   logic             turn_reg, turn_next;
   logic             picked_reg, picked_next;
   logic             over_reg, over_next;
   logic             winner_reg, winner_next;
   logic             err_reg, err_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             do_move;

   logic [4:0]       piece_bus [64];
   logic [767:0]     board_flat;
   logic [5:0]       cur_sq;
   logic [4:0]       cur_piece;
   logic [4:0]       src_piece;
   logic [4:0]       dst_piece;
   logic             own_cur;

   // Single action per cycle; the priority chain drops lower pulses.
   logic act_new, act_cancel, act_sel, act_up, act_down, act_left, act_right;
   logic no_hi;

   assign act_new    = bus.new_game;
   assign act_cancel = !bus.new_game && bus.btn_cancel;
   assign no_hi      = !bus.new_game && !bus.btn_cancel;
   assign act_sel    = no_hi && bus.btn_sel;
   assign act_up     = no_hi && !bus.btn_sel && bus.btn_up;
   assign act_down   = no_hi && !bus.btn_sel && !bus.btn_up && bus.btn_down;
   assign act_left   = no_hi && !bus.btn_sel && !bus.btn_up && !bus.btn_down
                       && bus.btn_left;
   assign act_right  = no_hi && !bus.btn_sel && !bus.btn_up && !bus.btn_down
                       && !bus.btn_left && bus.btn_right;

   assign cur_sq    = {row_reg, col_reg};
   assign cur_piece = piece_bus[cur_sq];
   assign src_piece = piece_bus[src_reg];
   assign dst_piece = piece_bus[dst_reg];
   assign own_cur   = cur_piece[0] && (cur_piece[1] == turn_reg);

   // Cursor clamps at the edges and moves in every state.
   always_comb begin
      row_next = row_reg;
      col_next = col_reg;
      if (act_new) begin
         row_next = 3'(INIT_ROW);
         col_next = 3'(INIT_COL);
      end else if (act_up && row_reg != 3'd0) begin
         row_next = row_reg - 3'd1;
      end else if (act_down && row_reg != 3'd7) begin
         row_next = row_reg + 3'd1;
      end else if (act_left && col_reg != 3'd0) begin
         col_next = col_reg - 3'd1;
      end else if (act_right && col_reg != 3'd7) begin
         col_next = col_reg + 3'd1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      src_next    = src_reg;
      dst_next    = dst_reg;
      turn_next   = turn_reg;
      picked_next = picked_reg;
      over_next   = over_reg;
      winner_next = winner_reg;
      err_next    = 1'b0;
      cnt_next    = cnt_reg;
      do_move     = 1'b0;
      case (state_reg)
         ST_PICK: begin
            if (act_sel) begin
               if (own_cur) begin
                  src_next    = cur_sq;
                  picked_next = 1'b1;
                  state_next  = ST_PLACE;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         ST_PLACE: begin
            if (act_cancel || (act_sel && cur_sq == src_reg)) begin
               picked_next = 1'b0;
               state_next  = ST_PICK;
            end else if (act_sel && own_cur) begin
               src_next = cur_sq;
            end else if (act_sel) begin
               dst_next   = cur_sq;
               state_next = ST_MOVE;
            end
         end
         ST_MOVE: begin
            // Select/cancel pulses arriving while the move commits are ignored.
            do_move     = 1'b1;
            picked_next = 1'b0;
            if (cnt_reg != {CNT_W{1'b1}}) begin
               cnt_next = cnt_reg + 1'b1;
            end
            if (dst_piece[4:2] == 3'b001) begin
               over_next   = 1'b1;
               winner_next = turn_reg;
               state_next  = ST_OVER;
            end else begin
               turn_next  = !turn_reg;
               state_next = ST_PICK;
            end
         end
         default: begin
            if (act_sel) begin
               err_next = 1'b1;
            end
         end
      endcase
      if (act_new) begin
         state_next  = ST_PICK;
         turn_next   = 1'b0;
         picked_next = 1'b0;
         over_next   = 1'b0;
         winner_next = 1'b0;
         err_next    = 1'b0;
         cnt_next    = '0;
         do_move     = 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         state_reg  <= ST_PICK;
         row_reg    <= 3'(INIT_ROW);
         col_reg    <= 3'(INIT_COL);
         src_reg    <= '0;
         dst_reg    <= '0;
         turn_reg   <= 1'b0;
         picked_reg <= 1'b0;
         over_reg   <= 1'b0;
         winner_reg <= 1'b0;
         err_reg    <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         row_reg    <= row_next;
         col_reg    <= col_next;
         src_reg    <= src_next;
         dst_reg    <= dst_next;
         turn_reg   <= turn_next;
         picked_reg <= picked_next;
         over_reg   <= over_next;
         winner_reg <= winner_next;
         err_reg    <= err_next;
         cnt_reg    <= cnt_next;
      end
   end

   // Per-square working piece and published word. The published word takes
   // the pre-edge live word, so a change in a frame_end cycle shows next frame.
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_sq
         logic [4:0]  piece_reg;
         logic [11:0] pub_reg;
         logic [11:0] live_word;

         always_ff @(posedge pclk or negedge rstn) begin
            if (!rstn) begin
               piece_reg <= init_piece(gi);
            end else if (act_new) begin
               piece_reg <= init_piece(gi);
            end else if (do_move && dst_reg == 6'(gi)) begin
               piece_reg <= src_piece;
            end else if (do_move && src_reg == 6'(gi)) begin
               piece_reg <= 5'b00000;
            end
         end

         assign live_word = {piece_reg, 3'b000, (cur_sq == 6'(gi)),
                             (picked_reg && src_reg == 6'(gi)), 2'b00};

         always_ff @(posedge pclk or negedge rstn) begin
            if (!rstn) begin
               pub_reg <= init_word(gi);
            end else if (bus.frame_end) begin
               pub_reg <= live_word;
            end
         end

         assign piece_bus[gi]            = piece_reg;
         assign board_flat[12*gi +: 12] = pub_reg;
      end
   endgenerate

   assign bus.board_data = board_flat;
   assign bus.turn       = turn_reg;
   assign bus.picked     = picked_reg;
   assign bus.game_over  = over_reg;
   assign bus.winner     = winner_reg;
   assign bus.err        = err_reg;
   assign bus.move_cnt   = cnt_reg;

endmodule

// File: tb/tb_chess_board_ctrl.sv
// Self-checking bench for chess_board_ctrl: directed game sequences followed
// by random button traffic, every cycle compared against a game-level model.
module tb_chess_board_ctrl;

   localparam int CNT_W = 10;
   localparam logic [7:0] UP  = 8'h01;
   localparam logic [7:0] DN  = 8'h02;
   localparam logic [7:0] LT  = 8'h04;
   localparam logic [7:0] RT  = 8'h08;
   localparam logic [7:0] SEL = 8'h10;
   localparam logic [7:0] CAN = 8'h20;
   localparam logic [7:0] NEW = 8'h40;
   localparam logic [7:0] FRM = 8'h80;

   logic pclk = 1'b0;
   logic rstn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always #5 pclk = ~pclk;

   chess_board_ctrl_if #(.CNT_W(CNT_W)) bus ();

   chess_board_ctrl #(.INIT_ROW(6), .INIT_COL(4), .CNT_W(CNT_W)) dut (
      .pclk (pclk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   // Game model: piece type 0 = empty, 1 king .. 6 pawn; black flag per square.
   int           m_type  [64];
   bit           m_black [64];
   int           m_row, m_col, m_src, m_dst, m_cnt;
   bit           m_picked, m_pending, m_turn, m_over, m_win, m_err;
   logic [767:0] m_pub;

   function automatic logic [767:0] render();
      logic [767:0] img;
      int           w;
      img = '0;
      for (int s = 0; s < 64; s++) begin
         w = 0;
         if (m_type[s] != 0) w = (m_type[s] << 9) + (int'(m_black[s]) << 8) + 128;
         if (s == m_row * 8 + m_col) w += 8;
         if (m_picked && s == m_src) w += 4;
         img[12*s +: 12] = 12'(w);
      end
      return img;
   endfunction

   task automatic model_reset(input bit with_pub);
      int back [8] = '{5, 4, 3, 2, 1, 3, 4, 5};
      for (int s = 0; s < 64; s++) begin
         m_type[s]  = 0;
         m_black[s] = 0;
      end
      for (int c = 0; c < 8; c++) begin
         m_type[c]      = back[c]; m_black[c]      = 1;
         m_type[8 + c]  = 6;       m_black[8 + c]  = 1;
         m_type[48 + c] = 6;       m_black[48 + c] = 0;
         m_type[56 + c] = back[c]; m_black[56 + c] = 0;
      end
      m_row = 6; m_col = 4; m_src = 0; m_dst = 0; m_cnt = 0;
      m_picked = 0; m_pending = 0; m_turn = 0; m_over = 0; m_win = 0; m_err = 0;
      if (with_pub) m_pub = render();
   endtask

   task automatic model_step(input logic [7:0] p);
      bit moving;
      bit own;
      int cur;
      if (p[7]) m_pub = render();
      m_err = 0;
      if (p[6]) begin
         model_reset(0);
         return;
      end
      moving = m_pending;
      if (moving) begin
         bit king_taken;
         king_taken = (m_type[m_dst] == 1);
         m_type[m_dst]  = m_type[m_src];
         m_black[m_dst] = m_black[m_src];
         m_type[m_src]  = 0;
         m_black[m_src] = 0;
         m_picked  = 0;
         m_pending = 0;
         if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         if (king_taken) begin
            m_over = 1;
            m_win  = m_turn;
         end else begin
            m_turn = !m_turn;
         end
      end
      cur = m_row * 8 + m_col;
      own = (m_type[cur] != 0) && (m_black[cur] == m_turn);
      if (p[5]) begin
         if (!moving && m_picked) m_picked = 0;
      end else if (p[4]) begin
         if (moving) begin
            // selection while a move commits has no effect
         end else if (m_over) begin
            m_err = 1;
         end else if (!m_picked) begin
            if (own) begin
               m_picked = 1;
               m_src    = cur;
            end else begin
               m_err = 1;
            end
         end else if (cur == m_src) begin
            m_picked = 0;
         end else if (own) begin
            m_src = cur;
         end else begin
            m_pending = 1;
            m_dst     = cur;
         end
      end else if (p[0]) begin
         if (m_row > 0) m_row--;
      end else if (p[1]) begin
         if (m_row < 7) m_row++;
      end else if (p[2]) begin
         if (m_col > 0) m_col--;
      end else if (p[3]) begin
         if (m_col < 7) m_col++;
      end
   endtask

   task automatic check_val(input string tag, input logic [767:0] got,
                            input logic [767:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_all();
      check_val("board_data", bus.board_data, m_pub);
      check_val("turn",       bus.turn,       m_turn);
      check_val("picked",     bus.picked,     m_picked);
      check_val("game_over",  bus.game_over,  m_over);
      check_val("winner",     bus.winner,     m_win);
      check_val("err",        bus.err,        m_err);
      check_val("move_cnt",   bus.move_cnt,   CNT_W'(m_cnt));
   endtask

   // One clock: drive pulses on the falling edge, sample 1 ns after the rising edge.
   task automatic cycle(input logic [7:0] p);
      @(negedge pclk);
      bus.btn_up     = p[0];
      bus.btn_down   = p[1];
      bus.btn_left   = p[2];
      bus.btn_right  = p[3];
      bus.btn_sel    = p[4];
      bus.btn_cancel = p[5];
      bus.new_game   = p[6];
      bus.frame_end  = p[7];
      @(posedge pclk);
      #1;
      cyc++;
      model_step(p);
      check_all();
      $display("[TB] cyc %0d in=%02h turn=%0d picked=%0d over=%0d err=%0d cnt=%0d",
               cyc, p, bus.turn, bus.picked, bus.game_over, bus.err, bus.move_cnt);
   endtask

   task automatic press(input logic [7:0] p, input int n);
      for (int k = 0; k < n; k++) cycle(p);
   endtask

   initial begin
      logic [7:0] p;
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      bus.btn_sel = 0; bus.btn_cancel = 0; bus.new_game = 0; bus.frame_end = 0;
      model_reset(1);
      #12;
      check_all();
      @(negedge pclk);
      rstn = 1'b1;

      // Published pawn with cursor at (6,4).
      cycle(FRM);
      check_val("sq52_reset", bus.board_data[52*12 +: 12], 12'hC88);

      // Cursor clamps at top and left edges.
      press(UP, 8);
      press(LT, 6);
      cycle(FRM);
      check_val("sq0_cursor", bus.board_data[11:0], 12'hB88);

      // Select on an opponent piece is rejected for one cycle.
      cycle(NEW);
      press(UP, 5);
      cycle(SEL);
      check_val("err_pulse", bus.err, 1'b1);
      cycle(8'h00);
      check_val("err_clear", bus.err, 1'b0);
      check_val("err_nopick", bus.picked, 1'b0);
      press(DN, 5);

      // Select beats up; the pick made with frame_end shows a frame later.
      cycle(SEL | UP | FRM);
      check_val("sq52_same_frame", bus.board_data[52*12 +: 12], 12'hC88);
      cycle(FRM);
      check_val("sq52_next_frame", bus.board_data[52*12 +: 12], 12'hC8C);
      press(UP, 2);
      cycle(SEL);
      cycle(8'h00);
      cycle(FRM);
      check_val("sq36_pawn", bus.board_data[36*12 +: 12], 12'hC88);
      check_val("sq52_empty", bus.board_data[52*12 +: 12], 12'h000);
      check_val("turn_black", bus.turn, 1'b1);
      check_val("cnt_one", bus.move_cnt, 10'd1);

      // Black pawn (1,4)->(2,4), then white pawn (4,4) takes the king at (0,4).
      press(UP, 3);
      cycle(SEL);
      cycle(DN);
      cycle(SEL);
      cycle(8'h00);
      press(DN, 2);
      cycle(SEL);
      press(UP, 4);
      cycle(SEL);
      cycle(8'h00);
      check_val("over_set", bus.game_over, 1'b1);
      check_val("winner_white", bus.winner, 1'b0);
      check_val("cnt_three", bus.move_cnt, 10'd3);
      cycle(SEL);
      check_val("err_over", bus.err, 1'b1);
      cycle(NEW);
      cycle(FRM);
      check_val("new_turn", bus.turn, 1'b0);
      check_val("new_over", bus.game_over, 1'b0);
      check_val("new_cnt", bus.move_cnt, 10'd0);
      check_val("new_sq52", bus.board_data[52*12 +: 12], 12'hC88);
      check_val("new_sq4", bus.board_data[4*12 +: 12], 12'h380);

      // Random traffic, overlapping pulses exercise the priority chain.
      for (int i = 0; i < 1200; i++) begin
         p    = 8'h00;
         p[0] = ($urandom_range(0, 3) == 0);
         p[1] = ($urandom_range(0, 3) == 0);
         p[2] = ($urandom_range(0, 3) == 0);
         p[3] = ($urandom_range(0, 3) == 0);
         p[4] = ($urandom_range(0, 4) == 0);
         p[5] = ($urandom_range(0, 19) == 0);
         p[6] = ($urandom_range(0, 299) == 0);
         p[7] = ($urandom_range(0, 7) == 0);
         cycle(p);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
